// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: valid/ready byte write port into a circular FIFO, drained
// by an 8N1 serializer on uart_tx. Bit period is DELAY_FRAMES clocks, the same
// timing scheme used by the companion UART receiver.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (11-bit frames). Ports are identical either way.
module uart_tx_buffered #(
  parameter int DELAY_FRAMES = 234,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  uart_tx,
  output logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int BW    = (DELAY_FRAMES > 2) ? $clog2(DELAY_FRAMES) : 1;

  localparam logic [BW-1:0]         BAUD_LAST  = BW'(DELAY_FRAMES - 1);
  localparam logic [BW-1:0]         BAUD_ONE   = BW'(1);
  localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;

  logic [2:0]            r_state;
  logic [BW-1:0]         r_baud;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  logic                  r_tx;

  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_nonempty;
  logic                  w_bit_end;

  // wr_ready looks only at the registered count, so a full FIFO never passes
  // a byte through even when the serializer pops on the same edge.
  assign w_ready    = (r_count < FULL_COUNT);
  assign w_push     = wr_valid && w_ready;
  assign w_nonempty = (r_count != '0);
  assign w_bit_end  = (r_baud == BAUD_LAST);
  // Pop from IDLE, or on the last clock of STOP to chain frames without a gap.
  assign w_pop      = w_nonempty &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  assign wr_ready   = w_ready;
  assign uart_tx    = r_tx;
  assign tx_busy    = (r_state != S_IDLE);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (wr_valid && !w_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Shift register takes the FIFO head whenever a frame begins.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
    end
  end

  // Baud counter: held at 0 in IDLE, otherwise wraps at DELAY_FRAMES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud <= '0;
    end else if ((r_state == S_IDLE) || w_bit_end) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + BAUD_ONE;
    end
  end

  // Frame sequencer; the line level for the next bit is registered on the
  // same edge that changes state, so uart_tx is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_START;
            r_tx    <= 1'b0;
          end else begin
            r_tx    <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= ^r_shift;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[r_bit_idx + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            if (w_nonempty) begin
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered (DELAY_FRAMES=4, DEPTH_LOG2=2). Stimulus pushes
// expected bytes into a scoreboard queue; a line monitor decodes frames from
// uart_tx and compares each against the queue head.
module tb_uart_tx_buffered;

  localparam int DF = 4;
  localparam int DL = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DF;

  logic          clk;
  logic          rst_n;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          uart_tx;
  logic          tx_busy;
  logic [DL:0]   fifo_count;
  logic          overflow;

  uart_tx_buffered #(.DELAY_FRAMES(DF), .DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         rst_epoch = 0;
  int         frames_seen = 0;
  logic       last_parity = 1'b0;
  logic [7:0] sb[$];
  int         frame_starts[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_epoch = rst_epoch + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Line monitor: start detected on a low sample, then one sample per bit
  // near the bit centre (1.5 clocks into the start bit, then every DF clocks).
  initial begin
    logic [10:0] bits;
    logic [7:0]  exp_b;
    int          ep;
    bits = '0;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx == 1'b0) begin
        ep = rst_epoch;
        frame_starts.push_back(cyc);
        for (int b = 0; b < NBITS; b++) begin
          repeat ((b == 0) ? 1 : DF) @(negedge clk);
          bits[b] = uart_tx;
        end
        if (ep == rst_epoch) begin
          frames_seen++;
          if (sb.size() == 0) begin
            check("unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
          end else begin
            exp_b = sb.pop_front();
            check("start_bit", bits[0], 1'b0);
            check("frame_data", bits[8:1], exp_b);
`ifdef UART_TX_PARITY_EN
            last_parity = bits[9];
            check("parity_bit", bits[9], ^exp_b);
`endif
            check("stop_bit", bits[NBITS-1], 1'b1);
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int max_cyc);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !tx_busy && fifo_count == '0) done = 1'b1;
    end
    check(name, done, 1'b1);
  endtask

  task automatic drive(input logic [7:0] d, input logic v);
    wr_data  = d;
    wr_valid = v;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    int snap;
    rst_n    = 1'b0;
    wr_data  = 8'h00;
    wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;

    // Idle for 50 clocks: {uart_tx,tx_busy,wr_ready,overflow,fifo_count}
    repeat (50) begin
      @(posedge clk); #1;
      check("idle_outputs", {uart_tx, tx_busy, wr_ready, overflow, fifo_count}, 7'b1010_000);
    end

    // Single byte 0x55
    sb.push_back(8'h55);
    drive(8'h55, 1'b1);
    wr_valid = 1'b0;
    check("t55_count_after_push", fifo_count, 1);
    check("t55_line_before_pop", uart_tx, 1'b1);
    @(posedge clk); #1;
    check("t55_line_falls", uart_tx, 1'b0);
    check("t55_count_after_pop", fifo_count, 0);
    busy_cnt = tx_busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx_busy) busy_cnt++;
      else break;
    end
    check("t55_busy_clocks", busy_cnt, FRAME);
    wait_drain("t55_drain", 200);

    // Three back-to-back bytes
    frame_starts.delete();
    sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03);
    drive(8'h01, 1'b1);
    check("t3_count0", fifo_count, 1);
    drive(8'h02, 1'b1);
    check("t3_count1", fifo_count, 1);
    drive(8'h03, 1'b1);
    check("t3_count2", fifo_count, 2);
    wr_valid = 1'b0;
    repeat (FRAME - 2) @(posedge clk);
    #1;
    check("t3_count_before_boundary", fifo_count, 2);
    @(posedge clk); #1;
    check("t3_count_after_boundary1", fifo_count, 1);
    repeat (FRAME) @(posedge clk);
    #1;
    check("t3_count_after_boundary2", fifo_count, 0);
    wait_drain("t3_drain", 300);
    check("t3_frame_cnt", frame_starts.size(), 3);
    if (frame_starts.size() == 3) begin
      check("t3_gap1", frame_starts[1] - frame_starts[0], FRAME);
      check("t3_gap2", frame_starts[2] - frame_starts[1], FRAME);
    end

    // Overflow: A0..A5 on consecutive clocks, A5 rejected
    check("ovf_clear_before", overflow, 1'b0);
    for (int i = 0; i < 5; i++) sb.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 6; i++) begin
      drive(8'hA0 + 8'(i), 1'b1);
      if (i == 4) begin
        check("ovf_ready_low_full", wr_ready, 1'b0);
        check("ovf_count_full", fifo_count, 4);
        check("ovf_not_yet", overflow, 1'b0);
      end
      if (i == 5) begin
        check("ovf_set", overflow, 1'b1);
        check("ovf_count_held", fifo_count, 4);
      end
    end
    wr_valid = 1'b0;
    wait_drain("ovf_drain", 5 * FRAME + 100);
    check("ovf_sticky", overflow, 1'b1);

    // Reset in the middle of DATA of 0xC3 with bytes queued behind it
    sb.push_back(8'hC3); sb.push_back(8'h11); sb.push_back(8'h22);
    drive(8'hC3, 1'b1);
    drive(8'h11, 1'b1);
    drive(8'h22, 1'b1);
    wr_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("rstmid_line_low_bit2", uart_tx, 1'b0);
    check("rstmid_count_before", fifo_count, 2);
    snap = frames_seen;
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rstmid_line_async_high", uart_tx, 1'b1);
    check("rstmid_busy", tx_busy, 1'b0);
    check("rstmid_count", fifo_count, 0);
    check("rstmid_overflow_cleared", overflow, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      check("rstmid_quiet", {uart_tx, tx_busy, wr_ready, overflow, fifo_count}, 7'b1010_000);
    end
    check("rstmid_no_frames", frames_seen, snap);

`ifdef UART_TX_PARITY_EN
    // Parity build: 0x07 has three ones, so even parity bit is 1
    sb.push_back(8'h07);
    drive(8'h07, 1'b1);
    wr_valid = 1'b0;
    @(posedge clk); #1;
    busy_cnt = tx_busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx_busy) busy_cnt++;
      else break;
    end
    check("par_busy_clocks", busy_cnt, 44);
    wait_drain("par_drain", 200);
    check("par_bit_07", last_parity, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
